frame_source: RTL and testbench

- Transmitter end of the frame stream protocol (fin_start / din_vld / din) consumed by the convolution pipeline.
- On a start command, it reads one frame, row-major, from an external synchronous frame buffer.
- It emits the frame as a pixel stream with a programmable idle gap after each row. The gap gives the row buffer and window/pad stages their row-turnaround time.
- Sits between the inter-layer frame memory and the input of the next conv3d layer.

---
 rtl/frame_pkg.sv | 17 +
 rtl/functions_pkg.sv | 16 +
 rtl/vld_delay_line.sv | 34 +++
 rtl/frame_source.sv | 205 ++++++++++++++++++++
 tb/tb_frame_source.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Types and constants shared by the frame source and its helpers.
// Latency: n/a.
// Backpressure: n/a.
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        GAP,
        DRAIN,
        FIN
    } frame_src_state_t;

    // Deepest frame buffer read pipeline the source can align against.
    localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/functions_pkg.sv
// Shared elaboration-time helper functions.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package functions_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vld_delay_line.sv
// Fixed-depth shift register that keeps strobes/flags aligned with read data.
// Latency: DEPTH cycles from i_dat to o_dat.
// Backpressure: none; shifts every cycle.
//
// Ports: i_clk, i_reset (sync active-high, clears every stage),
//        i_dat (WIDTH bits in), o_dat (WIDTH bits out, DEPTH cycles later).
module vld_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_dat = r_sr[DEPTH-1];

endmodule

// File: rtl/frame_source.sv
// Reads one frame row-major from a synchronous frame buffer and streams it out
// with a programmable idle gap after every row but the last.
// Latency: first rd_en 1 cycle after start; dout_vld RD_LATENCY after rd_en. No backpressure.
//
// Ports: clk, reset (sync active-high); frame_h/frame_w/row_gap/base_addr latched on
// an accepted start; busy, done (1-cycle pulse); rd_en/rd_addr/rd_data frame buffer
// port; fout_start/dout_vld/dout pixel stream (channel 0 in LSBs).
// Build option FRAME_SRC_EOL_EN adds dout_eol / dout_eof row and frame end markers.
module frame_source
    import functions_pkg::*;
    import frame_pkg::*;
#(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224,
    parameter int DIN_WIDTH   = 8,
    parameter int CH_NUM      = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int RD_LATENCY  = 1,
    parameter int GAP_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [clog2(FRAME_H_MAX):0]   frame_h,
    input  logic [clog2(FRAME_W_MAX):0]   frame_w,
    input  logic [GAP_WIDTH-1:0]          row_gap,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [CH_NUM*DIN_WIDTH-1:0]   rd_data,
    output logic                          fout_start,
    output logic                          dout_vld,
    output logic [CH_NUM*DIN_WIDTH-1:0]   dout
`ifdef FRAME_SRC_EOL_EN
    ,
    output logic                          dout_eol,
    output logic                          dout_eof
`endif
);

    localparam int HW    = clog2(FRAME_H_MAX) + 1;
    localparam int WW    = clog2(FRAME_W_MAX) + 1;
    localparam int DW    = CH_NUM * DIN_WIDTH;
    // One counter serves both the row gap and the drain wait.
    localparam int CNT_W = (GAP_WIDTH > clog2(RD_LATENCY_MAX)) ? GAP_WIDTH : clog2(RD_LATENCY_MAX);
`ifdef FRAME_SRC_EOL_EN
    localparam int DL_W  = 4;
`else
    localparam int DL_W  = 2;
`endif

    frame_src_state_t      r_state;
    logic [HW-1:0]         r_h;
    logic [HW-1:0]         r_row;
    logic [WW-1:0]         r_w;
    logic [WW-1:0]         r_col;
    logic [GAP_WIDTH-1:0]  r_gap;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DW-1:0]         r_dout_hold;

    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_first;
    logic [DL_W-1:0]       w_dl_in;
    logic [DL_W-1:0]       w_dl_out;
    logic [DW-1:0]         w_dout;

    // r_row/r_col always describe the read currently on the bus.
    assign w_last_col = (r_col == r_w - 1'b1);
    assign w_last_row = (r_row == r_h - 1'b1);
    assign w_first    = r_rd_en && (r_row == '0) && (r_col == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_h       <= '0;
            r_row     <= '0;
            r_w       <= '0;
            r_col     <= '0;
            r_gap     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            case (r_state)
                // FIN has busy=0, so a start there chains the next frame directly.
                IDLE, FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                    if (start) begin
                        r_h   <= frame_h;
                        r_w   <= frame_w;
                        r_gap <= row_gap;
                        r_row <= '0;
                        r_col <= '0;
                        if (frame_h == '0 || frame_w == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ROW;
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= base_addr;
                        end
                    end
                end
                // Row-major addresses are contiguous, so each read is previous + 1.
                ROW: begin
                    if (w_last_col) begin
                        r_col <= '0;
                        if (w_last_row) begin
                            r_state <= DRAIN;
                            r_rd_en <= 1'b0;
                            r_cnt   <= CNT_W'(RD_LATENCY - 1);
                        end else begin
                            r_row <= r_row + 1'b1;
                            if (r_gap != '0) begin
                                r_state <= GAP;
                                r_rd_en <= 1'b0;
                                r_cnt   <= CNT_W'(r_gap) - 1'b1;
                            end else begin
                                r_rd_addr <= r_rd_addr + 1'b1;
                            end
                        end
                    end else begin
                        r_col     <= r_col + 1'b1;
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        r_state   <= ROW;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // Let the last read emerge from the buffer before signalling done.
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_SRC_EOL_EN
    assign w_dl_in = {w_last_col && w_last_row && r_rd_en, w_last_col && r_rd_en, w_first, r_rd_en};
`else
    assign w_dl_in = {w_first, r_rd_en};
`endif

    vld_delay_line #(
        .DEPTH (RD_LATENCY),
        .WIDTH (DL_W)
    ) u_dly (
        .i_clk   (clk),
        .i_reset (reset),
        .i_dat   (w_dl_in),
        .o_dat   (w_dl_out)
    );

    // Pixel passes through on its valid beat; otherwise the last pixel is held.
    assign w_dout = w_dl_out[0] ? rd_data : r_dout_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_hold <= '0;
        end else begin
            r_dout_hold <= w_dout;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign dout_vld   = w_dl_out[0];
    assign fout_start = w_dl_out[1];
    assign dout       = w_dout;
`ifdef FRAME_SRC_EOL_EN
    assign dout_eol   = w_dl_out[2];
    assign dout_eof   = w_dl_out[3];
`endif

endmodule

// File: tb/tb_frame_source.sv
// Bench for frame_source: two instances (read latency 1 and 3) share the command
// inputs; each has its own frame buffer model. Observed events are logged per cycle
// and compared against a schedule derived from frame geometry.
module tb_frame_source;

    localparam int AW = 16;
    localparam int HW = 9;
    localparam int WW = 9;
    localparam int GW = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] val;
        logic [3:0]  flags;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [HW-1:0] frame_h = '0;
    logic [WW-1:0] frame_w = '0;
    logic [GW-1:0] row_gap = '0;
    logic [AW-1:0] base_addr = '0;
    logic          start = 1'b0;

    logic [1:0]    busy, done, rd_en, fout_start, dout_vld, dout_eol, dout_eof;
    logic [AW-1:0] rd_addr [2];
    logic [31:0]   rd_data [2];
    logic [31:0]   dout    [2];
    logic [31:0]   pipe    [2][4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // kind 0 = read strobe, 1 = output beat / fout_start, 2 = done
    ev_t act_q [2][3][$];
    ev_t exp_q [2][3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_source #(.RD_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset), .frame_h(frame_h), .frame_w(frame_w),
        .row_gap(row_gap), .base_addr(base_addr), .start(start),
        .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .fout_start(fout_start[0]), .dout_vld(dout_vld[0]),
        .dout(dout[0])
`ifdef FRAME_SRC_EOL_EN
        , .dout_eol(dout_eol[0]), .dout_eof(dout_eof[0])
`endif
    );

    frame_source #(.RD_LATENCY(3)) dut1 (
        .clk(clk), .reset(reset), .frame_h(frame_h), .frame_w(frame_w),
        .row_gap(row_gap), .base_addr(base_addr), .start(start),
        .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .fout_start(fout_start[1]), .dout_vld(dout_vld[1]),
        .dout(dout[1])
`ifdef FRAME_SRC_EOL_EN
        , .dout_eol(dout_eol[1]), .dout_eof(dout_eof[1])
`endif
    );

`ifndef FRAME_SRC_EOL_EN
    assign dout_eol = 2'b00;
    assign dout_eof = 2'b00;
`endif

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8], ~a[7:0], a[15:8] ^ 8'hC3};
    endfunction

    function automatic ev_t mk(input int c, input logic [31:0] v, input logic [3:0] f);
        ev_t e;
        e.cyc = c;
        e.val = v;
        e.flags = f;
        return e;
    endfunction

    // Frame buffer models: data appears lat(d) cycles after the strobe; junk otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe[d][0] <= (rd_en[d] === 1'b1) ? mem_word(rd_addr[d]) : $urandom();
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end
    assign rd_data[0] = pipe[0][0];
    assign rd_data[1] = pipe[1][2];

    always @(negedge clk) begin
        logic [3:0] fl;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rd_en[d] === 1'b1) act_q[d][0].push_back(mk(cyc, 32'(rd_addr[d]), 4'b0));
                fl = {dout_vld[d], fout_start[d], dout_eol[d], dout_eof[d]};
                if (fl !== 4'b0) act_q[d][1].push_back(mk(cyc, dout[d], fl));
                if (done[d] !== 1'b0) act_q[d][2].push_back(mk(cyc, 0, 4'b0));
            end
        end
    end

    // Reference schedule: start held over cycles t0..tend; a new frame is taken
    // whenever start is seen while not busy (including the done cycle).
    task automatic add_frames(input int t0, input int tend, input int h, input int w,
                              input int gap, input logic [15:0] base);
        int t, rc, last;
        logic [15:0] a;
        logic eol, eof;
        for (int d = 0; d < 2; d++) begin
            t = t0;
            while (t <= tend) begin
                if (h == 0 || w == 0) begin
                    exp_q[d][2].push_back(mk(t + 1, 0, 4'b0));
                    t = t + 1;
                end else begin
                    for (int r = 0; r < h; r++) begin
                        for (int c = 0; c < w; c++) begin
                            rc = t + 1 + r * w + c + r * gap;
                            a  = 16'(base + r * w + c);
`ifdef FRAME_SRC_EOL_EN
                            eol = (c == w - 1);
                            eof = eol && (r == h - 1);
`else
                            eol = 1'b0;
                            eof = 1'b0;
`endif
                            exp_q[d][0].push_back(mk(rc, 32'(a), 4'b0));
                            exp_q[d][1].push_back(mk(rc + lat(d), mem_word(a),
                                                     {1'b1, (r == 0 && c == 0), eol, eof}));
                        end
                    end
                    last = t + h * w + (h - 1) * gap;
                    exp_q[d][2].push_back(mk(last + lat(d) + 1, 0, 4'b0));
                    t = last + lat(d) + 1;
                end
            end
        end
    endtask

    task automatic clear_q;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                act_q[d][k].delete();
                exp_q[d][k].delete();
            end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; afterwards the command inputs are scrambled so any
    // use of unlatched values shows up.
    task automatic start_frame(input int h, input int w, input int gap,
                               input logic [15:0] base, output int t);
        @(posedge clk);
        #1;
        frame_h = HW'(h);
        frame_w = WW'(w);
        row_gap = GW'(gap);
        base_addr = base;
        start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        frame_h = HW'($urandom());
        frame_w = WW'($urandom());
        row_gap = GW'($urandom());
        base_addr = AW'($urandom());
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], rd_en[d], fout_start[d], dout_vld[d]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d: got %b want 00000", d,
                         {busy[d], done[d], rd_en[d], fout_start[d], dout_vld[d]});
            end
            checks++;
            if (rd_addr[d] !== 16'h0) begin
                errors++;
                $display("FAIL reset_addr dut%0d: got %h want 0000", d, rd_addr[d]);
            end
            checks++;
            if (dout[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_dout dut%0d: got %h want 0", d, dout[d]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], rd_en[d], dout_vld[d]} !== 3'b0) begin
                errors++;
                $display("FAIL idle_after_reset dut%0d: got %b want 000", d,
                         {busy[d], rd_en[d], dout_vld[d]});
            end
        end
    endtask

    task automatic test_contiguous;
        int t;
        clear_q();
        start_frame(3, 4, 0, 16'h0100, t);
        add_frames(t, t, 3, 4, 0, 16'h0100);
        run(30);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL contig dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL contig dut%0d kind%0d #%0d: got %h want %h", d, k, i,
                                 act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act_q[d][0].size() != 12 || act_q[d][0][11].val != 32'h010B) begin
                errors++;
                $display("FAIL contig_last_addr dut%0d: got n=%0d want n=12 ending 010B", d,
                         act_q[d][0].size());
            end
            checks++;
            if (act_q[d][2].size() != 1 || act_q[d][2][0].cyc != 32'(t + 12 + lat(d) + 1)) begin
                errors++;
                $display("FAIL contig_done_cycle dut%0d: got n=%0d want one done at %0d", d,
                         act_q[d][2].size(), t + 12 + lat(d) + 1);
            end
        end
    endtask

    task automatic test_row_gap;
        int t;
        logic [15:0] b;
        b = 16'($urandom());
        clear_q();
        start_frame(2, 3, 2, b, t);
        add_frames(t, t, 2, 3, 2, b);
        run(25);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL gap dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL gap dut%0d kind%0d #%0d: got %h want %h", d, k, i,
                                 act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act_q[d][1].size() < 6 || act_q[d][1][3].cyc - act_q[d][1][2].cyc != 3) begin
                errors++;
                $display("FAIL gap_idle dut%0d: got n=%0d want 2 idle cycles between beats 2 and 3",
                         d, act_q[d][1].size());
            end
`ifdef FRAME_SRC_EOL_EN
            checks++;
            if (act_q[d][1].size() < 6 || act_q[d][1][2].flags[1:0] !== 2'b10 ||
                act_q[d][1][5].flags[1:0] !== 2'b11 || act_q[d][1][4].flags[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL eol_eof dut%0d: got n=%0d want eol on beats 2,5 and eof on 5", d,
                         act_q[d][1].size());
            end
`endif
        end
    endtask

    task automatic test_empty_and_busy;
        int t, t2;
        clear_q();
        start_frame(3, 0, 1, 16'h1234, t);
        add_frames(t, t, 3, 0, 1, 16'h1234);
        run(6);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL empty dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL empty dut%0d kind%0d #%0d: got %h want %h", d, k, i,
                                 act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
        clear_q();
        start_frame(4, 4, 0, 16'h0040, t);
        run(3);
        start_frame(2, 2, 3, 16'h7000, t2);
        add_frames(t, t, 4, 4, 0, 16'h0040);
        run(30);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL busy_ignore dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL busy_ignore dut%0d kind%0d #%0d: got %h want %h", d, k, i,
                                 act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
    endtask

    task automatic test_addr_wrap;
        int t;
        logic [15:0] want [4];
        want[0] = 16'hFFFE;
        want[1] = 16'hFFFF;
        want[2] = 16'h0000;
        want[3] = 16'h0001;
        clear_q();
        start_frame(2, 2, 1, 16'hFFFE, t);
        add_frames(t, t, 2, 2, 1, 16'hFFFE);
        run(15);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL wrap dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL wrap dut%0d kind%0d #%0d: got %h want %h", d, k, i,
                                 act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4 && i < act_q[d][0].size(); i++) begin
                checks++;
                if (act_q[d][0][i].val[15:0] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_addr dut%0d #%0d: got %h want %h", d, i,
                             act_q[d][0][i].val[15:0], want[i]);
                end
            end
    endtask

    task automatic test_reset_mid_frame;
        int t;
        clear_q();
        start_frame(4, 4, 0, 16'h0200, t);
        run(2);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        clear_q();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], rd_en[d], fout_start[d], dout_vld[d]} !== 5'b0 ||
                rd_addr[d] !== 16'h0 || dout[d] !== 32'h0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: got ctrl=%b addr=%h dout=%h want all 0", d,
                         {busy[d], done[d], rd_en[d], fout_start[d], dout_vld[d]},
                         rd_addr[d], dout[d]);
            end
        end
        run(30);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== 0) begin
                    errors++;
                    $display("FAIL midreset_quiet dut%0d kind%0d: got %0d events want 0", d, k,
                             act_q[d][k].size());
                end
            end
        clear_q();
        start_frame(4, 4, 0, 16'h0300, t);
        add_frames(t, t, 4, 4, 0, 16'h0300);
        run(30);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL midreset_clean dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL midreset_clean dut%0d kind%0d #%0d: got %h want %h", d, k,
                                 i, act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
    endtask

    task automatic test_random;
        int t, h, w, g;
        logic [15:0] b;
        for (int n = 0; n < 6; n++) begin
            h = $urandom_range(1, 5);
            w = $urandom_range(0, 6);
            g = $urandom_range(0, 3);
            b = 16'($urandom());
            clear_q();
            start_frame(h, w, g, b, t);
            add_frames(t, t, h, w, g, b);
            run(h * w + h * g + 12);
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                        errors++;
                        $display("FAIL random%0d(%0dx%0d g%0d) dut%0d kind%0d count: got %0d want %0d",
                                 n, h, w, g, d, k, act_q[d][k].size(), exp_q[d][k].size());
                    end
                    for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                        checks++;
                        if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                            errors++;
                            $display("FAIL random%0d dut%0d kind%0d #%0d: got %h want %h", n, d,
                                     k, i, act_q[d][k][i], exp_q[d][k][i]);
                        end
                    end
                end
        end
    endtask

    task automatic test_back_to_back;
        int t0;
        logic [15:0] b;
        b = 16'($urandom());
        clear_q();
        @(posedge clk);
        #1;
        frame_h = 9'd2;
        frame_w = 9'd3;
        row_gap = 4'd1;
        base_addr = b;
        start = 1'b1;
        t0 = cyc;
        run(20);
        start = 1'b0;
        add_frames(t0, t0 + 19, 2, 3, 1, b);
        run(30);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_q[d][k].size() !== exp_q[d][k].size()) begin
                    errors++;
                    $display("FAIL b2b dut%0d kind%0d count: got %0d want %0d", d, k,
                             act_q[d][k].size(), exp_q[d][k].size());
                end
                for (int i = 0; i < act_q[d][k].size() && i < exp_q[d][k].size(); i++) begin
                    checks++;
                    if (act_q[d][k][i] !== exp_q[d][k][i]) begin
                        errors++;
                        $display("FAIL b2b dut%0d kind%0d #%0d: got %h want %h", d, k, i,
                                 act_q[d][k][i], exp_q[d][k][i]);
                    end
                end
            end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_contiguous();
        test_row_gap();
        test_empty_and_busy();
        test_addr_wrap();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
